// File: rtl/multi_prescaler_pkg.sv
// Shared types and the speed-code to counter-limit rule for multi_prescaler.
package multi_prescaler_pkg;

   localparam int unsigned SPEED_W     = 4;
   localparam int unsigned SPEED_CODES = 16;

   typedef logic [SPEED_W-1:0] speed_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } ch_state_t;

   // Terminal count giving a tick rate of (s+1) Hz from a clk_hz clock.
   function automatic int unsigned calc_limit(int unsigned clk_hz, speed_t s);
      return clk_hz / (32'(s) + 32'd1) - 32'd1;
   endfunction

endpackage

// File: rtl/prescaler_ch.sv
// One prescaler channel: continuous or one-shot tick generator with a live limit.
// Compile with MULTI_PRESCALER_SYNC_EN to add the sync input.
module prescaler_ch
   import multi_prescaler_pkg::*;
#(
   parameter int unsigned CNT_W = 26
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             oneshot,
   input  logic             arm,
`ifdef MULTI_PRESCALER_SYNC_EN
   input  logic             sync,
`endif
   input  logic [CNT_W-1:0] limit,
   output logic             tick,
   output logic             busy
);

   ch_state_t        state_q;
   ch_state_t        state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             mode_q;
   logic             mode_chg;
   logic             counting;
   logic             sync_hit;
   logic             wrap;
   logic             tick_d;
   logic             busy_d;

   assign mode_chg = (oneshot != mode_q);
   assign counting = oneshot ? (state_q == RUN) : 1'b1;

`ifdef MULTI_PRESCALER_SYNC_EN
   assign sync_hit = sync & ~oneshot;
`else
   assign sync_hit = 1'b0;
`endif

   // mode_q follows oneshot even in reset so release never looks like a mode change
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mode_q  <= oneshot;
         tick    <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= oneshot;
         tick    <= tick_d;
         busy    <= busy_d;
      end
   end

   // A count above a freshly lowered limit restarts the period without a tick
   always_comb begin : next_state_logic
      state_d = state_q;
      cnt_d   = cnt_q;
      wrap    = 1'b0;
      if (!en || mode_chg) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (sync_hit) begin
         cnt_d = '0;
      end else if (counting) begin
         if (cnt_q == limit) begin
            cnt_d   = '0;
            wrap    = 1'b1;
            state_d = IDLE;
         end else if (cnt_q > limit) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (oneshot && arm) begin
         state_d = RUN;
         cnt_d   = '0;
      end
   end

   always_comb begin : output_logic
      tick_d = 1'b0;
      busy_d = 1'b0;
      tick_d = wrap;
      busy_d = en && (!oneshot || (state_d == RUN));
   end

endmodule

// File: rtl/multi_prescaler.sv
// Bank of N_CH independent tick prescalers sharing one constant speed-to-limit table.
// Compile with MULTI_PRESCALER_SYNC_EN to add sync_i for phase-aligning continuous channels.
module multi_prescaler
   import multi_prescaler_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50_000_000,
   parameter int unsigned N_CH   = 4,
   parameter int unsigned CNT_W  = 26
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [N_CH-1:0]         en_i,
   input  logic [SPEED_W*N_CH-1:0] speed_i,
   input  logic [N_CH-1:0]         oneshot_i,
   input  logic [N_CH-1:0]         arm_i,
`ifdef MULTI_PRESCALER_SYNC_EN
   input  logic                    sync_i,
`endif
   output logic [N_CH-1:0]         tick_o,
   output logic [N_CH-1:0]         busy_o
);

   logic [CNT_W-1:0] limit_tab [SPEED_CODES];

   // Limits are elaboration-time constants, so no divider reaches the netlist
   for (genvar s = 0; s < SPEED_CODES; s++) begin : g_lim
      localparam logic [CNT_W-1:0] LIM = CNT_W'(calc_limit(CLK_HZ, speed_t'(s)));
      assign limit_tab[s] = LIM;
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      speed_t           spd;
      logic [CNT_W-1:0] lim;

      assign spd = speed_i[SPEED_W*k +: SPEED_W];
      assign lim = limit_tab[spd];

      prescaler_ch #(
         .CNT_W (CNT_W)
      ) u_ch (
         .clk     (clk_i),
         .rst     (rst_i),
         .en      (en_i[k]),
         .oneshot (oneshot_i[k]),
         .arm     (arm_i[k]),
`ifdef MULTI_PRESCALER_SYNC_EN
         .sync    (sync_i),
`endif
         .limit   (lim),
         .tick    (tick_o[k]),
         .busy    (busy_o[k])
      );
   end

endmodule

// File: doc/multi_prescaler.md
MULTI_PRESCALER -- requirements
Module: multi_prescaler

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter N_CH, default 4, meaning number of independent tick channels (1..16).
REQ-003 SHALL have parameter CNT_W, default 26, meaning counter width; must hold CLK_HZ-1.
REQ-004 SHALL have port clk_i  in  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port en_i  in  N_CH  per-channel enable.
REQ-007 SHALL have port speed_i  in  4*N_CH  per-channel speed code s; channel k uses bits [4k+3:4k].
REQ-008 SHALL have port oneshot_i  in  N_CH  per-channel mode: 0 continuous, 1 one-shot.
REQ-009 SHALL have port arm_i  in  N_CH  per-channel one-shot start pulse.
REQ-010 SHALL have port tick_o  out  N_CH  per-channel single-cycle tick, registered.
REQ-011 SHALL have port busy_o  out  N_CH  per-channel counting indicator, registered.

Function
REQ-012 Tick rate of channel k SHALL be (s+1) Hz: limit = CLK_HZ/(s+1) - 1 (integer division), period = limit+1 clock cycles.
REQ-013 Each channel SHALL hold a CNT_W-bit counter; increments by 1 per cycle while counting; on cnt == limit it returns to 0 and tick_o[k] is 1 in the following cycle only.
REQ-014 First tick SHALL appear exactly limit+1 cycles after the first counting cycle (counter starts at 0).
REQ-015 en_i[k]=0 SHALL force cnt to 0, tick_o[k]=0, busy_o[k]=0, and cancel any armed one-shot; en_i[k] rising restarts counting from 0 (continuous mode).
REQ-016 Continuous mode: busy_o[k]=1 whenever en_i[k]=1; arm_i[k] ignored.
REQ-017 One-shot mode states per channel: IDLE (cnt=0, busy=0) -> RUN on arm_i[k]=1 with en_i[k]=1; RUN -> IDLE on cnt == limit, emitting exactly one tick.
REQ-018 arm_i[k] during RUN SHALL be ignored (no retrigger, no extension).
REQ-019 Speed change SHALL take effect on the next cycle; if cnt > new limit, cnt restarts at 0 with no tick; otherwise counting continues to the new limit. No double tick ever within one new period.
REQ-020 Mode change (oneshot_i toggle) SHALL reset the channel to cnt=0; continuous->one-shot lands in IDLE.
REQ-021 Channels SHALL be fully independent; simultaneous ticks on any subset allowed.

Reset
REQ-022 rst_i=1 at a rising edge SHALL set all counters to 0, tick_o=0, busy_o=0, all channels IDLE, dominating all other inputs, including mid-period and mid-one-shot.
REQ-023 After rst_i deasserts, enabled continuous channels SHALL start counting in the first cycle with rst_i=0.

Configuration
REQ-024 Macro MULTI_PRESCALER_SYNC_EN SHALL, when defined, add input sync_i (1 bit): sync_i=1 restarts every enabled continuous channel at cnt=0 with no tick that cycle, phase-aligning all channels; one-shot channels unaffected.
REQ-025 Without MULTI_PRESCALER_SYNC_EN the sync_i port and logic SHALL not exist; behaviour otherwise identical.

Structure
REQ-026 Package multi_prescaler_pkg SHALL hold the speed-code typedef (4 bits), the channel-state enum (IDLE, RUN) and a constant function computing limit from CLK_HZ and s.
REQ-027 One sub-module prescaler_ch SHALL implement a single channel; the top instantiates N_CH copies via generate.
REQ-028 Limits SHALL be a 16-entry constant table per CLK_HZ; no runtime divider.

Verification (CLK_HZ=160, N_CH=4, CNT_W=8)
REQ-029 Reset 5 cycles, ch0 en, s=7 continuous -> ticks every 20 cycles, first tick 20 cycles after reset release; other channels silent.
REQ-030 ch0 s=7 at cnt=15, switch to s=15 (limit 9) -> cnt restarts, no tick, next tick 10 cycles later, then every 10.
REQ-031 ch1 one-shot s=3 (limit 39), arm pulse -> busy 40 cycles, one tick, then IDLE; second arm mid-run ignored.
REQ-032 ch2 s=0 and ch3 s=15 running, assert rst_i mid-period for 1 cycle -> all outputs 0 next cycle; restart phase-correct.
REQ-033 With MULTI_PRESCALER_SYNC_EN, ch0 s=7 and ch2 s=3, pulse sync_i -> both tick 20/40 cycles later, in phase.
REQ-034 Deassert en_i[1] during one-shot RUN -> busy drops next cycle, no tick; re-enable requires new arm.
